spiflash_responder: RTL and testbench
=====================================

Name: spiflash_responder

Overview:
- SPI-flash target (slave) that answers the serial read traffic issued by the PicoSoC flash controller.
- Flash contents come from an on-chip byte memory through a simple read port.
- Lets the SoC boot and execute from BRAM-backed "flash" with no external part, and serves as a synthesizable flash model in benches.
- Operates in the system clock domain; the SPI pins are oversampled.

Parameters:
- ADDR_BITS, 17: memory byte-address width; the 24-bit SPI address is truncated to its low ADDR_BITS bits.
- FAST_DUMMY, 8: dummy clocks after the address for command 0x0B.

Ports:
- clk  in  1  system clock; sole clock.
- reset  in  1  synchronous reset, active-high.
- spi_csb  in  1  chip select, active low, asynchronous to clk.
- spi_clk  in  1  SPI clock, mode 0, asynchronous to clk.
- spi_io0_di  in  1  MOSI from the controller.
- spi_io1_do  out  1  MISO data.
- spi_io1_oe  out  1  MISO output enable; the top level builds the tristate.
- mem_rd  out  1  one-cycle read strobe.
- mem_addr  out  ADDR_BITS  byte address; valid while mem_rd is high.
- mem_rdata  in  8  read data, valid exactly 1 clk after mem_rd.
- busy  out  1  high from CS assertion until CS release is detected.

Behaviour:
- Reset values: spi_io1_do=0, spi_io1_oe=0, mem_rd=0, mem_addr=0, busy=0, state=IDLE.
- Input sync: spi_csb, spi_clk and spi_io0_di each pass through 2-FF synchronizers. An SCK rise/fall is a change between the 2nd sync stage and a 3rd history flop. Events are therefore seen 2-3 clk after the pin change.
- Clock ratio: SCK high and low times must each be >= 4 clk periods. Faster SCK is unsupported and is not checked.
- Data order: MSB first on both lines. MOSI is sampled on the detected SCK rise. MISO is updated on the detected SCK fall.
- CS assert (synced csb falls): bit counter is cleared, busy=1, state goes to CMD.
- CMD: shift in 8 bits. On the 8th rise:
  - 0x03 -> ADDR, read mode.
  - 0x0B -> ADDR, fast mode.
  - Any other code (0xFF, 0xAB, 0x9F, ...) -> IGNORE.
- ADDR: shift in 24 bits. On the 24th rise:
  - mem_addr <= addr[ADDR_BITS-1:0], mem_rd=1 for one clk.
  - Next state is DATA (0x03) or DUMMY (0x0B).
- DUMMY: count FAST_DUMMY rises, then enter DATA. The byte fetched at the end of ADDR is held in the shift register.
- DATA:
  - spi_io1_oe=1 from the first detected fall in DATA.
  - On each fall the next bit goes out, starting with bit 7 of the fetched byte.
  - On the rise that completes bit 0 of a byte: mem_addr increments (wraps mod 2^ADDR_BITS) and mem_rd pulses. mem_rdata is loaded into the shift register before the next fall.
  - DATA continues indefinitely while CS stays low.
- IGNORE: spi_io1_oe=0. All SCK activity is ignored until CS release.
- CS release (synced csb rises), from any state:
  - spi_io1_oe=0 and busy=0 on the same clk; state goes to IDLE.
  - A partially transferred byte or address is discarded.
  - A mem_rd pulse already issued completes, but its data is dropped.
- Simultaneous CS release and SCK edge on the same clk: CS release wins.
- reset asserted mid-transaction: all outputs return to their reset values on the next clk. If reset releases with CS already low, state stays IDLE until the next CS assertion is detected, so the responder never joins a transfer mid-stream.
- spi_io1_do holds its last value when oe=0.
- No writes, no status register, no quad/dual modes. QSPI/DDR commands sent by the controller fall into IGNORE, so firmware must leave the controller in single-bit mode.

Decomposition:
- Shared package:
  - Command constants CMD_READ=8'h03 and CMD_FAST_READ=8'h0B.
  - State encoding IDLE/CMD/ADDR/DUMMY/DATA/IGNORE.
  - Address width 24.
- One sub-module: spi_pin_sync.
  - Instantiated once.
  - Synchronizes csb/sck/mosi.
  - Emits sck_rise, sck_fall, cs_start, cs_end and mosi_s pulses/levels.
- Memory is external to this block; the top level pairs it with a $readmemh-initialized BRAM.

Test Plan:
- 0x03 read: mem[0x10]=A5, mem[0x11]=3C; send 03 00 00 10 at SCK=clk/8, clock 16 bits -> MISO returns A5 then 3C; mem_addr sequence 0x10, 0x11, 0x12; oe high only in DATA.
- 0x0B fast read: mem[0x0200]=5A; send 0B 00 02 00 + 8 dummy clocks -> first data byte 5A; oe stays 0 during dummy.
- Address wrap: ADDR_BITS=17, read 03 01 FF FF for 2 bytes -> mem_addr 0x1FFFF then 0x00000; data matches mem[0x1FFFF] and mem[0].
- CS abort: raise csb after 3 data bits -> oe=0 and busy=0 within 3 clk. A following 03 00 00 10 returns A5 correctly.
- Unsupported commands: send FF, then AB, then 9F with 24 clocks -> oe never asserts, mem_rd never pulses; busy follows CS.
- Reset mid-DATA: assert reset for 1 clk while CS is low -> outputs at reset values next clk; no response until CS toggles, then a normal 0x03 read succeeds.

Source files
------------

// File: rtl/spiflash_responder_pkg.sv
// Shared constants and state encoding for the SPI-flash responder.
package spiflash_responder_pkg;

   localparam logic [7:0] CMD_READ      = 8'h03;
   localparam logic [7:0] CMD_FAST_READ = 8'h0B;
   localparam int         SPI_ADDR_BITS = 24;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CMD    = 3'd1,
      ADDR   = 3'd2,
      DUMMY  = 3'd3,
      DATA   = 3'd4,
      IGNORE = 3'd5
   } state_t;

endpackage

// File: rtl/spiflash_responder_pin_sync.sv
// Brings csb/sck/mosi into clk and turns SCK and CS transitions into one-clk pulses.
module spi_pin_sync (
   input  logic clk,
   input  logic spi_csb,
   input  logic spi_clk,
   input  logic spi_io0_di,
   output logic sck_rise,
   output logic sck_fall,
   output logic cs_start,
   output logic cs_end,
   output logic mosi_s
);

   logic [2:0] csb_sr;
   logic [2:0] sck_sr;
   logic [1:0] mosi_sr;

   // Left unreset so a reset during a live transfer cannot fabricate a CS edge.
   always_ff @(posedge clk) begin
      csb_sr  <= {csb_sr[1:0], spi_csb};
      sck_sr  <= {sck_sr[1:0], spi_clk};
      mosi_sr <= {mosi_sr[0], spi_io0_di};
   end

   assign sck_rise = sck_sr[1] & ~sck_sr[2];
   assign sck_fall = ~sck_sr[1] & sck_sr[2];
   assign cs_start = ~csb_sr[1] & csb_sr[2];
   assign cs_end   = csb_sr[1] & ~csb_sr[2];
   assign mosi_s   = mosi_sr[1];

endmodule

// File: rtl/spiflash_responder.sv
// SPI-flash read responder (0x03 / 0x0B) serving bytes from an external byte memory.
//
// state  | meaning
// IDLE   | CS high, or waiting for a fresh CS assertion after reset
// CMD    | shifting in the 8-bit command
// ADDR   | shifting in the 24-bit address; fetch issued on the last bit
// DUMMY  | counting dummy clocks for fast read
// DATA   | streaming bytes out on MISO, auto-incrementing address
// IGNORE | unsupported command; wait for CS release
module spiflash_responder
   import spiflash_responder_pkg::*;
#(
   parameter int ADDR_BITS  = 17,
   parameter int FAST_DUMMY = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 spi_csb,
   input  logic                 spi_clk,
   input  logic                 spi_io0_di,
   output logic                 spi_io1_do,
   output logic                 spi_io1_oe,
   output logic                 mem_rd,
   output logic [ADDR_BITS-1:0] mem_addr,
   input  logic [7:0]           mem_rdata,
   output logic                 busy
);

   localparam int DUMMY_W = (FAST_DUMMY > 1) ? $clog2(FAST_DUMMY) : 1;

   logic sck_rise;
   logic sck_fall;
   logic cs_start;
   logic cs_end;
   logic mosi_s;

   spi_pin_sync u_sync (
      .clk        (clk),
      .spi_csb    (spi_csb),
      .spi_clk    (spi_clk),
      .spi_io0_di (spi_io0_di),
      .sck_rise   (sck_rise),
      .sck_fall   (sck_fall),
      .cs_start   (cs_start),
      .cs_end     (cs_end),
      .mosi_s     (mosi_s)
   );

   state_t               state;
   logic [4:0]           bit_cnt;
   logic [DUMMY_W-1:0]   dummy_cnt;
   logic                 fast_mode;
   logic                 rd_pending;
   logic [ADDR_BITS-2:0] shift_sr;
   logic [7:0]           dout_sr;
   logic [ADDR_BITS-1:0] addr_next;
   logic [7:0]           cmd_next;

   // Only the low ADDR_BITS of the 24-bit address survive the shift.
   assign addr_next = {shift_sr, mosi_s};
   assign cmd_next  = addr_next[7:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         dummy_cnt  <= '0;
         fast_mode  <= 1'b0;
         rd_pending <= 1'b0;
         shift_sr   <= '0;
         dout_sr    <= '0;
         spi_io1_do <= 1'b0;
         spi_io1_oe <= 1'b0;
         mem_rd     <= 1'b0;
         mem_addr   <= '0;
         busy       <= 1'b0;
      end else begin
         mem_rd     <= 1'b0;
         rd_pending <= mem_rd;
         if (rd_pending && !cs_end && state != IDLE)
            dout_sr <= mem_rdata;

         if (cs_end) begin
            state      <= IDLE;
            spi_io1_oe <= 1'b0;
            busy       <= 1'b0;
         end else if (cs_start) begin
            state      <= CMD;
            bit_cnt    <= '0;
            spi_io1_oe <= 1'b0;
            busy       <= 1'b1;
         end else begin
            case (state)
               IDLE: ;
               CMD: begin
                  if (sck_rise) begin
                     shift_sr <= addr_next[ADDR_BITS-2:0];
                     if (bit_cnt == 5'd7) begin
                        bit_cnt <= '0;
                        if (cmd_next == CMD_READ) begin
                           state     <= ADDR;
                           fast_mode <= 1'b0;
                        end else if (cmd_next == CMD_FAST_READ) begin
                           state     <= ADDR;
                           fast_mode <= 1'b1;
                        end else begin
                           state <= IGNORE;
                        end
                     end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                     end
                  end
               end
               ADDR: begin
                  if (sck_rise) begin
                     shift_sr <= addr_next[ADDR_BITS-2:0];
                     if (bit_cnt == 5'd23) begin
                        bit_cnt  <= '0;
                        mem_addr <= addr_next;
                        mem_rd   <= 1'b1;
                        if (fast_mode && FAST_DUMMY > 0) begin
                           state     <= DUMMY;
                           dummy_cnt <= DUMMY_W'(FAST_DUMMY - 1);
                        end else begin
                           state <= DATA;
                        end
                     end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                     end
                  end
               end
               DUMMY: begin
                  if (sck_rise) begin
                     if (dummy_cnt == '0)
                        state <= DATA;
                     else
                        dummy_cnt <= dummy_cnt - 1'b1;
                  end
               end
               DATA: begin
                  if (sck_fall) begin
                     spi_io1_oe <= 1'b1;
                     spi_io1_do <= dout_sr[7];
                     dout_sr    <= {dout_sr[6:0], 1'b0};
                  end else if (sck_rise) begin
                     if (bit_cnt == 5'd7) begin
                        bit_cnt  <= '0;
                        mem_addr <= mem_addr + 1'b1;
                        mem_rd   <= 1'b1;
                     end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                     end
                  end
               end
               IGNORE: spi_io1_oe <= 1'b0;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spiflash_responder.sv
// Directed bench: a table of read/ignore transactions plus abort and reset-mid-read sequences.
module tb_spiflash_responder;

   localparam int AB = 17;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          spi_csb = 1'b1;
   logic          spi_clk = 1'b0;
   logic          spi_io0_di = 1'b0;
   logic          spi_io1_do;
   logic          spi_io1_oe;
   logic          mem_rd;
   logic [AB-1:0] mem_addr;
   logic [7:0]    mem_rdata = 8'h00;
   logic          busy;

   spiflash_responder #(.ADDR_BITS(AB), .FAST_DUMMY(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .spi_csb    (spi_csb),
      .spi_clk    (spi_clk),
      .spi_io0_di (spi_io0_di),
      .spi_io1_do (spi_io1_do),
      .spi_io1_oe (spi_io1_oe),
      .mem_rd     (mem_rd),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [0:(1<<AB)-1];
   always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

   logic [AB-1:0] rd_log[$];
   int            oe_bad = 0;
   bit            oe_allowed = 1'b0;
   always @(negedge clk) begin
      if (mem_rd) rd_log.push_back(mem_addr);
      if (spi_io1_oe && !oe_allowed) oe_bad++;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic spi_bit(input logic b, output logic r);
      spi_clk = 1'b0;
      spi_io0_di = b;
      repeat (4) @(negedge clk);
      r = spi_io1_do;
      spi_clk = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(tx[i], r);
         rx[i] = r;
      end
   endtask

   task automatic cs_low();
      spi_csb = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic cs_high();
      spi_clk = 1'b0;
      repeat (2) @(negedge clk);
      spi_csb = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   typedef struct {
      string         name;
      logic [7:0]    cmd;
      logic [23:0]   addr;
      int            ndummy;
      int            nbytes;
      logic [7:0]    exp_b0;
      logic [7:0]    exp_b1;
      int            exp_nrd;
      logic [AB-1:0] exp_a0;
      logic [AB-1:0] exp_a1;
      logic [AB-1:0] exp_a2;
   } vec_t;

   vec_t vecs[7];

   task automatic run_vec(input vec_t v);
      logic [7:0]    rx;
      logic          r;
      int            rd0;
      int            bad0;
      logic [AB-1:0] ea[3];
      ea[0] = v.exp_a0; ea[1] = v.exp_a1; ea[2] = v.exp_a2;
      rd0  = rd_log.size();
      bad0 = oe_bad;
      oe_allowed = 1'b0;
      cs_low();
      check({v.name, " busy_cs_low"}, 32'(busy), 32'd1);
      spi_byte(v.cmd, rx);
      spi_byte(v.addr[23:16], rx);
      spi_byte(v.addr[15:8], rx);
      spi_byte(v.addr[7:0], rx);
      for (int i = 0; i < v.ndummy; i++) spi_bit(1'b0, r);
      if (v.nbytes > 0) begin
         oe_allowed = 1'b1;
         spi_byte(8'h00, rx);
         check({v.name, " byte0"}, 32'(rx), 32'(v.exp_b0));
         check({v.name, " oe_in_data"}, 32'(spi_io1_oe), 32'd1);
      end
      if (v.nbytes > 1) begin
         spi_byte(8'h00, rx);
         check({v.name, " byte1"}, 32'(rx), 32'(v.exp_b1));
      end
      cs_high();
      oe_allowed = 1'b0;
      check({v.name, " busy_cs_high"}, 32'(busy), 32'd0);
      check({v.name, " oe_cs_high"}, 32'(spi_io1_oe), 32'd0);
      check({v.name, " oe_outside_data"}, 32'(oe_bad - bad0), 32'd0);
      check({v.name, " rd_count"}, 32'(rd_log.size() - rd0), 32'(v.exp_nrd));
      for (int k = 0; k < v.exp_nrd && k < 3; k++)
         if (rd0 + k < rd_log.size())
            check({v.name, " rd_addr"}, 32'(rd_log[rd0 + k]), 32'(ea[k]));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rx;
      logic       r;
      logic [2:0] rbits;
      int         rd0;
      int         bad0;

      for (int i = 0; i < (1 << AB); i++) mem[i] = 8'h00;
      mem[17'h00010] = 8'hA5;
      mem[17'h00011] = 8'h3C;
      mem[17'h00200] = 8'h5A;
      mem[17'h00201] = 8'hC3;
      mem[17'h1FFFF] = 8'hE7;
      mem[17'h00000] = 8'h81;

      vecs[0] = '{"read03",   8'h03, 24'h000010, 0, 2, 8'hA5, 8'h3C, 3, 17'h00010, 17'h00011, 17'h00012};
      vecs[1] = '{"fast0B",   8'h0B, 24'h000200, 8, 2, 8'h5A, 8'hC3, 3, 17'h00200, 17'h00201, 17'h00202};
      vecs[2] = '{"wrap",     8'h03, 24'h01FFFF, 0, 2, 8'hE7, 8'h81, 3, 17'h1FFFF, 17'h00000, 17'h00001};
      vecs[3] = '{"truncate", 8'h03, 24'hFE0010, 0, 1, 8'hA5, 8'h00, 2, 17'h00010, 17'h00011, 17'h00000};
      vecs[4] = '{"cmdFF",    8'hFF, 24'h000000, 0, 0, 8'h00, 8'h00, 0, 17'h0, 17'h0, 17'h0};
      vecs[5] = '{"cmdAB",    8'hAB, 24'h000000, 0, 0, 8'h00, 8'h00, 0, 17'h0, 17'h0, 17'h0};
      vecs[6] = '{"cmd9F",    8'h9F, 24'h000000, 0, 0, 8'h00, 8'h00, 0, 17'h0, 17'h0, 17'h0};

      repeat (5) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst do",   32'(spi_io1_do), 32'd0);
      check("rst oe",   32'(spi_io1_oe), 32'd0);
      check("rst rd",   32'(mem_rd), 32'd0);
      check("rst addr", 32'(mem_addr), 32'd0);
      check("rst busy", 32'(busy), 32'd0);

      foreach (vecs[i]) run_vec(vecs[i]);

      // CS released three bits into the first data byte
      oe_allowed = 1'b0;
      cs_low();
      spi_byte(8'h03, rx);
      spi_byte(8'h00, rx);
      spi_byte(8'h00, rx);
      spi_byte(8'h10, rx);
      oe_allowed = 1'b1;
      for (int i = 2; i >= 0; i--) begin
         spi_bit(1'b0, r);
         rbits[i] = r;
      end
      check("abort bits", 32'(rbits), 32'h5);
      spi_csb = 1'b1;
      repeat (3) @(negedge clk);
      check("abort oe",   32'(spi_io1_oe), 32'd0);
      check("abort busy", 32'(busy), 32'd0);
      spi_clk = 1'b0;
      repeat (6) @(negedge clk);
      oe_allowed = 1'b0;
      run_vec(vecs[0]);

      // reset pulse in the middle of the second data byte, CS held low
      cs_low();
      spi_byte(8'h03, rx);
      spi_byte(8'h00, rx);
      spi_byte(8'h00, rx);
      spi_byte(8'h10, rx);
      oe_allowed = 1'b1;
      spi_byte(8'h00, rx);
      check("pre_reset byte0", 32'(rx), 32'hA5);
      spi_bit(1'b0, r);
      spi_bit(1'b0, r);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mid_rst do",   32'(spi_io1_do), 32'd0);
      check("mid_rst oe",   32'(spi_io1_oe), 32'd0);
      check("mid_rst rd",   32'(mem_rd), 32'd0);
      check("mid_rst addr", 32'(mem_addr), 32'd0);
      check("mid_rst busy", 32'(busy), 32'd0);
      oe_allowed = 1'b0;
      rd0  = rd_log.size();
      bad0 = oe_bad;
      for (int i = 0; i < 16; i++) spi_bit(1'b1, r);
      check("post_rst oe",   32'(oe_bad - bad0), 32'd0);
      check("post_rst rd",   32'(rd_log.size() - rd0), 32'd0);
      check("post_rst busy", 32'(busy), 32'd0);
      cs_high();
      run_vec(vecs[0]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
